// File: rtl/i2c_write24_controller_if.sv
// i2c_write24_controller_if: GO/END request handshake between the config sequencer and the I2C write engine.
interface i2c_write24_controller_if;
    logic        iGO;
    logic [23:0] iDATA;
    logic        oEND;
    logic        oACK;
    logic        oBUSY;
    modport master(output iGO, iDATA, input oEND, oACK, oBUSY);
    modport slave(input iGO, iDATA, output oEND, oACK, oBUSY);
endinterface

// File: rtl/i2c_write24_controller.sv
// i2c_write24_controller: emits one START / 3-byte / STOP I2C write frame per GO request.
// All bus activity is paced by a quarter-bit tick from the system clock.
module i2c_write24_controller #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 20000
) (
    input  logic                        iCLK,
    input  logic                        iRST_N,
    i2c_write24_controller_if.slave     ctl,
    output logic                        I2C_SCLK,
    inout  wire                         I2C_SDAT
);
    localparam int DIV_Q = CLK_Freq / (4 * I2C_Freq);
    localparam int DW = $clog2(DIV_Q);
    typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;
    state_t      state;
    logic [DW-1:0] div;
    logic [1:0]  ph;
    logic [3:0]  bitCnt;
    logic [1:0]  byteCnt;
    logic [23:0] sh;
    logic        acc;
    logic        sdaLow;
    logic        tick;
    logic        ackSlot;
    assign tick = ctl.oBUSY && div == DW'(DIV_Q - 1);
    assign ackSlot = bitCnt == 4'd8;
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state <= IDLE;
            div <= '0;
            ph <= '0;
            bitCnt <= '0;
            byteCnt <= '0;
            sh <= '0;
            acc <= 1'b0;
            sdaLow <= 1'b0;
            I2C_SCLK <= 1'b1;
            ctl.oEND <= 1'b0;
            ctl.oACK <= 1'b0;
            ctl.oBUSY <= 1'b0;
        end else begin
            div <= (ctl.oBUSY && !tick) ? div + 1'b1 : '0;
            if (tick) ph <= ph + 1'b1;
            case (state)
                IDLE: if (ctl.iGO && !ctl.oEND) begin
                    sh <= ctl.iDATA;
                    acc <= 1'b0;
                    ctl.oACK <= 1'b0;
                    ctl.oBUSY <= 1'b1;
                    ph <= '0;
                    bitCnt <= '0;
                    byteCnt <= '0;
                    state <= START;
                end
                START: if (tick) begin
                    if (ph == 2'd0) sdaLow <= 1'b1;
                    else begin
                        I2C_SCLK <= 1'b0;
                        ph <= '0;
                        state <= BITS;
                    end
                end
                // each bit slot: p0 set data, p1 SCL up, p2 sample ACK, p3 SCL down
                BITS: if (tick) begin
                    case (ph)
                        2'd0: sdaLow <= !ackSlot && !sh[23];
                        2'd1: I2C_SCLK <= 1'b1;
                        2'd2: if (ackSlot) acc <= acc | I2C_SDAT;
                        2'd3: begin
                            I2C_SCLK <= 1'b0;
                            bitCnt <= ackSlot ? 4'd0 : bitCnt + 1'b1;
                            if (ackSlot) byteCnt <= byteCnt + 1'b1;
                            else sh <= {sh[22:0], 1'b0};
                            if (ackSlot && byteCnt == 2'd2) state <= STOP;
                        end
                    endcase
                end
                STOP: if (tick) begin
                    if (ph == 2'd0) sdaLow <= 1'b1;
                    else if (ph == 2'd1) I2C_SCLK <= 1'b1;
                    else begin
                        sdaLow <= 1'b0;
                        ctl.oEND <= 1'b1;
                        ctl.oACK <= acc;
                        ctl.oBUSY <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: if (!ctl.iGO) begin
                    ctl.oEND <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_write24_controller.md
Name: i2c_write24_controller

Overview:
- Serial engine downstream of the audio-codec configuration sequencer.
- Accepts one 24-bit write request {slave address, sub-address, data} via a GO/END handshake.
- Emits a complete I2C write frame (START, 3 bytes with ACK slots, STOP) on SCLK/SDAT.
- Reports whether every byte was acknowledged. Runs on the system clock using an internal quarter-bit tick; no derived clocks.

Parameters:
CLK_Freq  50000000  system clock frequency, Hz
I2C_Freq  20000  SCL frequency, Hz
DIV_Q  CLK_Freq/(4*I2C_Freq)  system cycles per quarter-bit tick (625 at defaults); must be >=2

Ports:
iCLK  input  1  system clock
iRST_N  input  1  synchronous active-low reset
iGO  input  1  transfer request; level, held by requester until oEND
iDATA  input  24  [23:16] slave addr+R/W, [15:8] sub-addr, [7:0] data
oEND  output  1  transfer complete; held until iGO sampled low
oACK  output  1  1 = at least one NACK in last frame; valid while oEND=1
oBUSY  output  1  frame in progress
I2C_SCLK  output  1  I2C clock, push-pull, idle high
I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or Z, never 1

Behaviour:
- Reset: sampled on iCLK rising edge with iRST_N=0. Next edge: I2C_SCLK=1, I2C_SDAT=Z, oEND=0, oACK=0, oBUSY=0, state IDLE, divider=0. Applies mid-frame with no STOP generated; the requester re-runs its sequence.
- Tick: divider counts 0..DIV_Q-1 while oBUSY=1. Tick fires when it wraps. Divider is cleared on transfer accept.
- States: IDLE, START, BITS, STOP, DONE.
- IDLE:
  - SCLK=1, SDAT=Z.
  - If iGO=1 and oEND=0 at edge N: latch iDATA into shift register, clear ACK accumulator, oBUSY=1, go START.
  - Tick k then occurs at edge N + k*DIV_Q.
- START, 2 ticks:
  - t1: SDAT=0 (SCL still 1).
  - t2: SCLK=0.
- BITS: 27 bit slots (3 bytes x {8 data bits MSB first, 1 ACK slot}), 4 ticks each:
  - p0: SCLK=0; SDAT=0 if bit=0, else Z. ACK slots always Z.
  - p1: SCLK=1.
  - p2: SCLK=1. In ACK slots only, sample SDAT; Z/1 reads as NACK and ORs into the accumulator.
  - p3: SCLK=0.
  - Ticks 3..110.
- STOP, 3 ticks:
  - t111: SDAT=0, SCLK=0.
  - t112: SCLK=1.
  - t113: SDAT=Z.
- DONE:
  - At the tick-113 edge: oEND=1, oACK=accumulator, oBUSY=0.
  - Each following edge: if iGO=0, oEND=0 and go IDLE; else hold oEND=1. A new frame needs iGO low for at least 1 cycle.
- Latency: accept at edge N, oEND high at edge N+113*DIV_Q.
- NACK never aborts the frame. All 3 bytes and STOP are always sent; oACK reports the failure and the requester retries.
- iGO dropped mid-frame: ignored; frame completes. oEND is then high for exactly 1 cycle.
- iDATA changes after accept: ignored (latched copy used).
- oACK is held from DONE until the next accept. It is cleared only at accept and reset.
- SCL/SDA change only on tick edges. SDAT never changes while SCLK=1, except START (t1) and STOP (t113).

Test Plan:
1. Reset: hold iRST_N=0 with iGO=1 for 3 cycles, then release with iGO=0 -> SCLK=1, SDAT=Z, oEND=0, oACK=0, oBUSY=0 throughout; no SCL edges.
2. DIV_Q=4; iDATA=0x341E00, iGO=1; slave model pulls SDAT low in all 3 ACK slots -> START, then bits 00110100 / 00011110 / 00000000 sampled on SCL rise. oEND rises exactly 452 cycles after accept, oACK=0, then STOP.
3. iDATA=0x34047B; slave NACKs byte 2 only -> full 27 slots plus STOP still sent; oACK=1 at oEND.
4. Hold iGO=1 for 50 cycles after oEND -> oEND stays 1, no new START. Drop iGO 1 cycle, raise again -> oEND falls, second frame begins with oACK cleared.
5. Pulse iGO for 1 cycle and change iDATA to 0xFFFFFF at tick 20 -> frame still carries the original value. oEND is a single-cycle pulse.
6. Assert iRST_N=0 at tick 50 (mid byte 2) -> next edge SCLK=1, SDAT=Z, oBUSY=0. Then a clean 0x341201 frame completes with oACK=0.
